// File: rtl/nios2_ht18_wang_fu_ocimem_pkg.sv
// Shared definitions for the OCI RAM access controller: FSM states, jdo field
// positions and default RAM geometry.
package nios2_ht18_wang_fu_ocimem_pkg;

  localparam int OCI_ADDR_W   = 8;
  localparam int OCI_DEPTH    = 1 << OCI_ADDR_W;

  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_RD_FLAG  = 17;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_JRD  = 3'd1,
    ST_JWR  = 3'd2,
    ST_CRD  = 3'd3,
    ST_CWR  = 3'd4,
    ST_RDAT = 3'd5
  } ocimem_state_e;

endpackage

// File: rtl/nios2_ht18_wang_fu_ocimem_ram.sv
// Single-port synchronous OCI RAM, read latency 1, returning the old word on a
// same-cycle read/write to one address.
module nios2_ht18_wang_fu_ocimem_ram
  import nios2_ht18_wang_fu_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic              wren,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] q_r;

  // Array write and read register; the read samples the array before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem_r[address] <= data;
    end
    q_r <= mem_r[address];
  end

  assign q = q_r;

endmodule

// File: rtl/nios2_ht18_wang_fu_ocimem_access_ctrl.sv
// OCI RAM sequencer: decodes JTAG action strobes and arbitrates the RAM against the CPU debug slave.
// Define NIOS2_HT18_WANG_FU_OCIMEM_WRPROT_EN to discard CPU writes made with debugaccess low.
module nios2_ht18_wang_fu_ocimem_access_ctrl
  import nios2_ht18_wang_fu_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic              debugaccess,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_e     state_r;
  ocimem_state_e     state_nxt_s;
  logic              pending_r;
  logic              pend_wr_r;
  logic              last_jtag_r;
  logic              rd_jtag_r;
  logic [DATA_W-1:0] mon_d_r;
  logic [ADDR_W-1:0] mon_a_r;
  logic              ready_r;
  logic              error_r;
  logic [DATA_W-1:0] cpu_rdata_r;

  logic              queue_s;
  logic              jtag_done_s;
  logic              overrun_s;
  logic              accept_s;
  logic              cpu_req_s;
  logic              grant_jtag_s;
  logic              rdat_cpu_s;
  logic              cpu_done_s;
  logic              wr_allow_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_wren_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_q_s;

  assign queue_s      = take_action_ocimem_b | take_no_action_ocimem_a
                      | (take_action_ocimem_a & jdo[JDO_RD_FLAG]);
  assign jtag_done_s  = (state_r == ST_JWR) | ((state_r == ST_RDAT) & rd_jtag_r);
  // A strobe landing on the completion cycle finds the slot free again.
  assign overrun_s    = queue_s & pending_r & ~jtag_done_s;
  assign accept_s     = queue_s & ~overrun_s;
  assign cpu_req_s    = cpu_read | cpu_write;
  assign grant_jtag_s = pending_r & ~(cpu_req_s & last_jtag_r);
  assign rdat_cpu_s   = (state_r == ST_RDAT) & ~rd_jtag_r;

`ifdef NIOS2_HT18_WANG_FU_OCIMEM_WRPROT_EN
  logic jdo_unused_s;
  assign wr_allow_s   = debugaccess;
  assign jdo_unused_s = ^{jdo[37:35], jdo[2:0]};
`else
  logic jdo_unused_s;
  assign wr_allow_s   = 1'b1;
  assign jdo_unused_s = ^{jdo[37:35], jdo[2:0], debugaccess};
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE arbitrates, every access then runs to completion.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_jtag_s) begin
          state_nxt_s = pend_wr_r ? ST_JWR : ST_JRD;
        end else if (cpu_read) begin
          state_nxt_s = ST_CRD;
        end else if (cpu_write) begin
          state_nxt_s = ST_CWR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_JRD:  state_nxt_s = ST_RDAT;
      ST_CRD:  state_nxt_s = ST_RDAT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // RAM port drive and CPU completion, decoded from the current state.
  always_comb begin
    ram_addr_s  = mon_a_r;
    ram_wren_s  = 1'b0;
    ram_wdata_s = mon_d_r;
    cpu_done_s  = 1'b0;
    case (state_r)
      ST_JWR: ram_wren_s = 1'b1;
      ST_CRD: ram_addr_s = cpu_address;
      ST_CWR: begin
        ram_addr_s  = cpu_address;
        ram_wdata_s = cpu_writedata;
        ram_wren_s  = wr_allow_s;
        cpu_done_s  = 1'b1;
      end
      ST_RDAT: cpu_done_s = ~rd_jtag_r;
      default: cpu_done_s = 1'b0;
    endcase
  end

  // JTAG pending slot plus grant bookkeeping (alternation and RDAT owner).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r   <= 1'b0;
      pend_wr_r   <= 1'b0;
      last_jtag_r <= 1'b0;
      rd_jtag_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        pending_r <= 1'b1;
        pend_wr_r <= take_action_ocimem_b;
      end else if (jtag_done_s) begin
        pending_r <= 1'b0;
      end
      if ((state_r == ST_IDLE) && (state_nxt_s != ST_IDLE)) begin
        last_jtag_r <= grant_jtag_s;
        rd_jtag_r   <= grant_jtag_s;
      end
    end
  end

  // JTAG-facing registers; a fresh strobe takes precedence over a same-cycle completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_r <= '0;
      mon_d_r <= '0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      if (take_action_ocimem_a & ~overrun_s) begin
        mon_a_r <= jdo[JDO_ADDR_LO +: ADDR_W];
      end else if (jtag_done_s) begin
        mon_a_r <= mon_a_r + ADDR_W'(1);
      end
      if (take_action_ocimem_b & ~overrun_s) begin
        mon_d_r <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
      end else if ((state_r == ST_RDAT) & rd_jtag_r) begin
        mon_d_r <= ram_q_s;
      end
      if (take_action_ocimem_a) begin
        ready_r <= 1'b0;
      end else if (jtag_done_s) begin
        ready_r <= 1'b1;
      end
      if (overrun_s) begin
        error_r <= 1'b1;
      end else if (take_action_ocimem_a) begin
        error_r <= 1'b0;
      end
    end
  end

  // Holds the last CPU read word between CPU reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_r <= '0;
    end else if (rdat_cpu_s) begin
      cpu_rdata_r <= ram_q_s;
    end
  end

  nios2_ht18_wang_fu_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .address (ram_addr_s),
    .wren    (ram_wren_s),
    .data    (ram_wdata_s),
    .q       (ram_q_s)
  );

  // The RAM read register is presented directly in the CPU's RDAT cycle.
  assign cpu_readdata    = rdat_cpu_s ? ram_q_s : cpu_rdata_r;
  assign cpu_waitrequest = cpu_req_s & ~cpu_done_s;
  assign MonDReg         = mon_d_r;
  assign MonAReg         = mon_a_r;
  assign monitor_ready   = ready_r;
  assign monitor_error   = error_r;

endmodule
